// File: rtl/fb_bank_sequencer.sv
// Frame-buffer sequencer: camera burst writes, VGA burst reads, bank rotation
// so the VGA side only ever reads a fully written frame.
`timescale 1ns/1ps
module fb_bank_sequencer #(
  parameter int COL_W            = 9,
  parameter int ROW_W            = 13,
  parameter int BANK_W           = 2,
  parameter int NUM_BANKS        = 3,
  parameter int BURSTS_PER_FRAME = 750,
  parameter int FIFO_W           = 11,
  parameter int WR_THRESH        = 512,
  parameter int RD_THRESH        = 512
) (
  input  logic                          clk_133M,
  input  logic                          rst_133,
  input  logic                          cam_vsyn,
  input  logic                          vga_vsyn,
  input  logic [FIFO_W-1:0]             wr_fifo_used,
  input  logic [FIFO_W-1:0]             rd_fifo_used,
  input  logic                          wr_sdram_ack,
  input  logic                          rd_sdram_ack,
  output logic                          wr_sdram_req,
  output logic [BANK_W+ROW_W+COL_W-1:0] wr_sdram_add,
  output logic                          rd_sdram_req,
  output logic [BANK_W+ROW_W+COL_W-1:0] rd_sdram_add,
  output logic                          clear_wrsdram_fifo,
  output logic                          clear_rdsdram_fifo,
  output logic [BANK_W-1:0]             cam_bank,
  output logic [BANK_W-1:0]             vga_bank,
  output logic                          frame_valid,
  output logic                          frame_drop,
  output logic                          short_frame
);

  localparam logic [ROW_W-1:0]  BPF  = ROW_W'(BURSTS_PER_FRAME);
  localparam logic [FIFO_W-1:0] WR_T = FIFO_W'(WR_THRESH);
  localparam logic [FIFO_W-1:0] RD_T = FIFO_W'(RD_THRESH);

  typedef enum logic {W_IDLE, W_REQ} wr_state_t;
  typedef enum logic {R_IDLE, R_REQ} rd_state_t;

  wr_state_t         wr_state, wr_state_nxt;
  rd_state_t         rd_state, rd_state_nxt;
  logic [2:0]        cam_sync, vga_sync;
  logic              cam_start, vga_start;
  logic [ROW_W-1:0]  wr_cnt, rd_cnt;
  logic [BANK_W-1:0] last_done;
  logic              wr_en, consumed;

  logic              frame_done, short_cond, drop_cond, found, consumed_nxt;
  logic [BANK_W-1:0] last_nxt, vga_nxt, cam_nxt;

  assign cam_start = cam_sync[2] & ~cam_sync[1];
  assign vga_start = ~vga_sync[2] & vga_sync[1];

  // Bank selection sees last_done/vga_bank as they will be after any
  // same-cycle promotion and VGA frame start.
  always_comb begin
    frame_done   = wr_en && (wr_cnt == BPF);
    short_cond   = wr_en && !frame_done && frame_valid;
    last_nxt     = (cam_start && frame_done) ? cam_bank : last_done;
    vga_nxt      = vga_start ? last_nxt : vga_bank;
    consumed_nxt = vga_start ? 1'b1 : ((cam_start && frame_done) ? 1'b0 : consumed);
    cam_nxt      = cam_bank;
    drop_cond    = 1'b0;
    found        = 1'b0;
    if (NUM_BANKS == 2) begin
      cam_nxt   = (vga_nxt == '0) ? BANK_W'(1) : '0;
      drop_cond = (cam_nxt == last_nxt) && !consumed_nxt;
    end else begin
      for (int unsigned i = 0; i < NUM_BANKS; i++) begin
        if (!found && BANK_W'(i) != vga_nxt && BANK_W'(i) != last_nxt) begin
          cam_nxt = BANK_W'(i);
          found   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_133M) begin
    if (rst_133) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
    end else begin
      wr_state <= wr_state_nxt;
      rd_state <= rd_state_nxt;
    end
  end

  always_comb begin
    wr_state_nxt = wr_state;
    rd_state_nxt = rd_state;
    case (wr_state)
      W_IDLE: if (!cam_start && wr_fifo_used >= WR_T && wr_cnt < BPF && wr_en)
                wr_state_nxt = W_REQ;
      W_REQ:  if (cam_start || wr_sdram_ack) wr_state_nxt = W_IDLE;
      default: wr_state_nxt = W_IDLE;
    endcase
    case (rd_state)
      R_IDLE: if (!vga_start && rd_fifo_used <= RD_T && rd_cnt < BPF && frame_valid)
                rd_state_nxt = R_REQ;
      R_REQ:  if (vga_start || rd_sdram_ack) rd_state_nxt = R_IDLE;
      default: rd_state_nxt = R_IDLE;
    endcase
    wr_sdram_req = (wr_state == W_REQ);
    rd_sdram_req = (rd_state == R_REQ);
    wr_sdram_add = {cam_bank, wr_cnt, COL_W'(0)};
    rd_sdram_add = {vga_bank, rd_cnt, COL_W'(0)};
  end

  always_ff @(posedge clk_133M) begin
    if (rst_133) begin
      cam_sync           <= '0;
      vga_sync           <= '0;
      wr_cnt             <= '0;
      rd_cnt             <= '0;
      cam_bank           <= '0;
      vga_bank           <= '0;
      last_done          <= '0;
      wr_en              <= 1'b0;
      consumed           <= 1'b0;
      frame_valid        <= 1'b0;
      frame_drop         <= 1'b0;
      short_frame        <= 1'b0;
      clear_wrsdram_fifo <= 1'b0;
      clear_rdsdram_fifo <= 1'b0;
    end else begin
      cam_sync           <= {cam_sync[1:0], cam_vsyn};
      vga_sync           <= {vga_sync[1:0], vga_vsyn};
      clear_wrsdram_fifo <= cam_start;
      clear_rdsdram_fifo <= vga_start;
      short_frame        <= cam_start && short_cond;
      frame_drop         <= cam_start && drop_cond;
      consumed           <= consumed_nxt;
      if (cam_start) begin
        last_done   <= last_nxt;
        frame_valid <= frame_valid | frame_done;
        cam_bank    <= cam_nxt;
        wr_en       <= !drop_cond;
        wr_cnt      <= '0;
      end else if (wr_state == W_REQ && wr_sdram_ack) begin
        wr_cnt <= wr_cnt + ROW_W'(1);
      end
      if (vga_start) begin
        vga_bank <= vga_nxt;
        rd_cnt   <= '0;
      end else if (rd_state == R_REQ && rd_sdram_ack) begin
        rd_cnt <= rd_cnt + ROW_W'(1);
      end
    end
  end

  always_ff @(posedge clk_133M) begin
    if (!rst_133) assert (!(wr_en && cam_bank == vga_bank));
  end

endmodule

// File: tb/tb_fb_bank_sequencer.sv
// Bench for fb_bank_sequencer: a 3-bank full-size instance and a 2-bank short-frame
// instance, driven by randomized handshakes and checked against a frame-level model.
`timescale 1ns/1ps
module tb_fb_bank_sequencer;

  localparam int AW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [1:0]           cam_vsyn, vga_vsyn, wr_ack, rd_ack;
  logic [1:0][10:0]     wr_used, rd_used;
  logic [1:0]           wr_req, rd_req, clr_wr, clr_rd, fvalid, fdrop, fshort;
  logic [1:0][AW-1:0]   wr_add, rd_add;
  logic [1:0][1:0]      cam_bank, vga_bank;

  fb_bank_sequencer #(.NUM_BANKS(3), .BURSTS_PER_FRAME(750)) u3 (
    .clk_133M(clk), .rst_133(rst), .cam_vsyn(cam_vsyn[0]), .vga_vsyn(vga_vsyn[0]),
    .wr_fifo_used(wr_used[0]), .rd_fifo_used(rd_used[0]),
    .wr_sdram_ack(wr_ack[0]), .rd_sdram_ack(rd_ack[0]),
    .wr_sdram_req(wr_req[0]), .wr_sdram_add(wr_add[0]),
    .rd_sdram_req(rd_req[0]), .rd_sdram_add(rd_add[0]),
    .clear_wrsdram_fifo(clr_wr[0]), .clear_rdsdram_fifo(clr_rd[0]),
    .cam_bank(cam_bank[0]), .vga_bank(vga_bank[0]), .frame_valid(fvalid[0]),
    .frame_drop(fdrop[0]), .short_frame(fshort[0]));

  fb_bank_sequencer #(.NUM_BANKS(2), .BURSTS_PER_FRAME(8)) u2 (
    .clk_133M(clk), .rst_133(rst), .cam_vsyn(cam_vsyn[1]), .vga_vsyn(vga_vsyn[1]),
    .wr_fifo_used(wr_used[1]), .rd_fifo_used(rd_used[1]),
    .wr_sdram_ack(wr_ack[1]), .rd_sdram_ack(rd_ack[1]),
    .wr_sdram_req(wr_req[1]), .wr_sdram_add(wr_add[1]),
    .rd_sdram_req(rd_req[1]), .rd_sdram_add(rd_add[1]),
    .clear_wrsdram_fifo(clr_wr[1]), .clear_rdsdram_fifo(clr_rd[1]),
    .cam_bank(cam_bank[1]), .vga_bank(vga_bank[1]), .frame_valid(fvalid[1]),
    .frame_drop(fdrop[1]), .short_frame(fshort[1]));

  // Frame-level reference state per instance
  int unsigned m_cam[2], m_vga[2], m_last[2], m_valid[2], m_en[2], m_cons[2], m_wc[2], m_rc[2];
  int unsigned nb[2]  = '{3, 2};
  int unsigned bpf[2] = '{750, 8};
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_addr(input int unsigned bank, input int unsigned row);
    return (bank << 22) | (row << 9);
  endfunction

  function automatic logic [10:0] wr_hi();
    if ($urandom_range(0, 3) == 0) return 11'd512;
    return 11'($urandom_range(513, 2047));
  endfunction
  function automatic logic [10:0] wr_lo();
    if ($urandom_range(0, 3) == 0) return 11'd511;
    return 11'($urandom_range(0, 510));
  endfunction
  function automatic logic [10:0] rd_ok();
    if ($urandom_range(0, 3) == 0) return 11'd512;
    return 11'($urandom_range(0, 511));
  endfunction
  function automatic logic [10:0] rd_block();
    if ($urandom_range(0, 3) == 0) return 11'd513;
    return 11'($urandom_range(514, 2047));
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cam[d] = 0; m_vga[d] = 0; m_last[d] = 0; m_valid[d] = 0;
      m_en[d] = 0; m_cons[d] = 0; m_wc[d] = 0; m_rc[d] = 0;
    end
  endtask

  task automatic model_starts(input int d, input bit c, input bit v, output bit e_short, output bit e_drop);
    bit done;
    done    = c && m_en[d] != 0 && m_wc[d] == bpf[d];
    e_short = c && m_en[d] != 0 && !done && m_valid[d] != 0;
    e_drop  = 1'b0;
    if (done) begin
      m_last[d] = m_cam[d]; m_valid[d] = 1; m_cons[d] = 0;
    end
    if (v) begin
      m_vga[d] = m_last[d]; m_cons[d] = 1; m_rc[d] = 0;
    end
    if (c) begin
      m_wc[d] = 0;
      if (nb[d] == 3) begin
        for (int b = 2; b >= 0; b--)
          if (b != m_vga[d] && b != m_last[d]) m_cam[d] = b;
        m_en[d] = 1;
      end else begin
        m_cam[d] = 1 - m_vga[d];
        if (m_cam[d] == m_last[d] && m_cons[d] == 0) begin
          m_en[d] = 0; e_drop = 1'b1;
        end else begin
          m_en[d] = 1;
        end
      end
    end
  endtask

  task automatic sync_edge(input int d, input bit c, input bit v, input bit ack);
    bit es, ed;
    wr_used[d] = wr_lo();
    rd_used[d] = rd_block();
    if (c) cam_vsyn[d] = 1'b0;
    if (v) vga_vsyn[d] = 1'b1;
    cycle();
    cycle();
    if (ack) wr_ack[d] = 1'b1;
    model_starts(d, c, v, es, ed);
    cycle();
    wr_ack[d] = 1'b0;
    chk("cam_bank", cam_bank[d], m_cam[d]);
    chk("vga_bank", vga_bank[d], m_vga[d]);
    chk("frame_valid", fvalid[d], m_valid[d]);
    chk("clear_wr_pulse", clr_wr[d], c);
    chk("clear_rd_pulse", clr_rd[d], v);
    chk("short_frame", fshort[d], es);
    chk("frame_drop", fdrop[d], ed);
    if (c) chk("wr_req_dropped_at_start", wr_req[d], 0);
    cycle();
    chk("clear_wr_end", clr_wr[d], 0);
    chk("clear_rd_end", clr_rd[d], 0);
    chk("short_end", fshort[d], 0);
    chk("drop_end", fdrop[d], 0);
    cam_vsyn[d] = 1'b1;
    vga_vsyn[d] = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic wr_burst(input int d);
    int n;
    bit seen;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      wr_used[d] = wr_lo();
      cycle();
      chk("wr_gate", wr_req[d], 0);
    end
    wr_used[d] = wr_hi();
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      cycle();
      seen = (wr_req[d] === 1'b1);
    end
    chk("wr_req_rise", seen, 1);
    chk("wr_addr", wr_add[d], exp_addr(m_cam[d], m_wc[d]));
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      wr_used[d] = 11'($urandom_range(0, 2047));
      cycle();
      chk("wr_req_hold", wr_req[d], 1);
      chk("wr_addr_stable", wr_add[d], exp_addr(m_cam[d], m_wc[d]));
    end
    wr_ack[d] = 1'b1;
    cycle();
    wr_ack[d] = 1'b0;
    m_wc[d]++;
    chk("wr_req_after_ack", wr_req[d], 0);
    wr_used[d] = wr_lo();
  endtask

  task automatic rd_burst(input int d);
    int n;
    bit seen;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      rd_used[d] = rd_block();
      cycle();
      chk("rd_gate", rd_req[d], 0);
    end
    rd_used[d] = rd_ok();
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      cycle();
      seen = (rd_req[d] === 1'b1);
    end
    chk("rd_req_rise", seen, 1);
    chk("rd_addr", rd_add[d], exp_addr(m_vga[d], m_rc[d]));
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      cycle();
      chk("rd_req_hold", rd_req[d], 1);
      chk("rd_addr_stable", rd_add[d], exp_addr(m_vga[d], m_rc[d]));
    end
    rd_ack[d] = 1'b1;
    cycle();
    rd_ack[d] = 1'b0;
    m_rc[d]++;
    chk("rd_req_after_ack", rd_req[d], 0);
    rd_used[d] = rd_block();
  endtask

  task automatic wr_quiet(input int d, input string tag);
    wr_used[d] = wr_hi();
    repeat (5) begin
      cycle();
      chk(tag, wr_req[d], 0);
    end
    wr_used[d] = wr_lo();
    cycle();
  endtask

  task automatic chk_reset_outputs();
    for (int d = 0; d < 2; d++) begin
      chk("rst_wr_req", wr_req[d], 0);
      chk("rst_rd_req", rd_req[d], 0);
      chk("rst_wr_add", wr_add[d], 0);
      chk("rst_rd_add", rd_add[d], 0);
      chk("rst_clear_wr", clr_wr[d], 0);
      chk("rst_clear_rd", clr_rd[d], 0);
      chk("rst_cam_bank", cam_bank[d], 0);
      chk("rst_vga_bank", vga_bank[d], 0);
      chk("rst_frame_valid", fvalid[d], 0);
      chk("rst_frame_drop", fdrop[d], 0);
      chk("rst_short_frame", fshort[d], 0);
    end
  endtask

  initial begin
    int n;
    bit seen;
    rst = 1'b1;
    cam_vsyn = 2'b11; vga_vsyn = 2'b00; wr_ack = 2'b00; rd_ack = 2'b00;
    wr_used = '0; rd_used = {11'd2047, 11'd2047};
    model_reset();
    repeat (5) cycle();
    chk_reset_outputs();
    rst = 1'b0;
    repeat (3) cycle();

    // Nothing may be requested before the first camera frame start / first valid frame
    wr_used = {wr_hi(), wr_hi()};
    rd_used = {rd_ok(), rd_ok()};
    repeat (4) begin
      cycle();
      chk("idle_wr_req0", wr_req[0], 0);
      chk("idle_wr_req1", wr_req[1], 0);
      chk("idle_rd_req0", rd_req[0], 0);
      chk("idle_rd_req1", rd_req[1], 0);
    end
    wr_used = '0; rd_used = {11'd2047, 11'd2047};
    cycle();

    // Reset in the middle of an outstanding write request
    sync_edge(0, 1'b1, 1'b0, 1'b0);
    wr_used[0] = wr_hi();
    cycle(); cycle();
    chk("pre_rst_req", wr_req[0], 1);
    rst = 1'b1;
    cycle();
    chk("rst_drops_req", wr_req[0], 0);
    chk("rst_cam_bank_mid", cam_bank[0], 0);
    rst = 1'b0;
    wr_used[0] = '0;
    model_reset();
    repeat (3) cycle();

    // Three-bank instance: full frame, promotion, read, short frame
    sync_edge(0, 1'b1, 1'b0, 1'b0);
    repeat (750) wr_burst(0);
    wr_quiet(0, "wr_saturated");
    sync_edge(0, 1'b1, 1'b0, 1'b0);
    sync_edge(0, 1'b0, 1'b1, 1'b0);
    repeat (4) rd_burst(0);
    n = $urandom_range(200, 500);
    repeat (n) wr_burst(0);
    sync_edge(0, 1'b1, 1'b0, 1'b0);
    sync_edge(0, 1'b0, 1'b1, 1'b0);
    rd_burst(0);

    // Two-bank instance: drop, simultaneous edges, ack discarded at frame start
    sync_edge(1, 1'b1, 1'b0, 1'b0);
    repeat (8) wr_burst(1);
    wr_quiet(1, "wr_saturated2");
    sync_edge(1, 1'b1, 1'b0, 1'b0);
    wr_quiet(1, "wr_dropped_frame");
    sync_edge(1, 1'b1, 1'b1, 1'b0);
    repeat (3) wr_burst(1);
    wr_used[1] = wr_hi();
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      cycle();
      seen = (wr_req[1] === 1'b1);
    end
    chk("wr_req_before_start", seen, 1);
    sync_edge(1, 1'b1, 1'b0, 1'b1);
    repeat (8) wr_burst(1);
    wr_quiet(1, "wr_saturated3");
    sync_edge(1, 1'b1, 1'b1, 1'b0);
    repeat (2) rd_burst(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
